// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: bus configuration, response codes, command/response beats.
// Pure declarations, no timing.
// Holding structs are sized for the widest bus (64-bit addr, 8 data bytes).
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned A;  // address width in bits
    int unsigned N;  // data width in bytes (4 or 8)
  } axi4_lite_cfg_t;

  localparam int unsigned AXI4_LITE_MAX_A = 64;
  localparam int unsigned AXI4_LITE_MAX_N = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi4_lite_resp_t;

  typedef struct packed {
    logic                           write;
    logic [AXI4_LITE_MAX_A-1:0]     addr;
    logic [AXI4_LITE_MAX_N*8-1:0]   wdata;
    logic [AXI4_LITE_MAX_N-1:0]     wstrb;
  } axi4_lite_cmd_t;

  typedef struct packed {
    logic                           write;
    logic [AXI4_LITE_MAX_N*8-1:0]   rdata;
    axi4_lite_resp_t                resp;
  } axi4_lite_rsp_t;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R) with master and slave views.
// No logic, no latency.
// Flow control is the standard per-channel valid/ready pair.
interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = '{default: 0}
);

  logic                 awvalid;
  logic                 awready;
  logic [C.A-1:0]       awaddr;
  logic [2:0]           awprot;

  logic                 wvalid;
  logic                 wready;
  logic [C.N*8-1:0]     wdata;
  logic [C.N-1:0]       wstrb;

  logic                 bvalid;
  logic                 bready;
  logic [1:0]           bresp;

  logic                 arvalid;
  logic                 arready;
  logic [C.A-1:0]       araddr;
  logic [2:0]           arprot;

  logic                 rvalid;
  logic                 rready;
  logic [C.N*8-1:0]     rdata;
  logic [1:0]           rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi4_lite_cmd_stats.sv
// Saturating write/read/error counters over completed response handshakes.
// Counts are visible the cycle after the handshake edge.
// No backpressure; samples a single-cycle handshake strobe.
module axi4_lite_cmd_stats #(
  parameter int unsigned STATS_W = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               rsp_hs,
  input  logic               rsp_write,
  input  logic               rsp_err,
  output logic [STATS_W-1:0] stat_wr_cnt,
  output logic [STATS_W-1:0] stat_rd_cnt,
  output logic [STATS_W-1:0] stat_err_cnt
);

  logic [STATS_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [STATS_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [STATS_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Bump the matching counter on each response handshake, holding at all-ones.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (rsp_hs) begin
      if (rsp_write) wr_cnt_d = sat_inc(wr_cnt_q);
      else           rd_cnt_d = sat_inc(rd_cnt_q);
      if (rsp_err)   err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_err_cnt = err_cnt_q;

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// Command-stream to single AXI4-Lite transaction master, one transaction outstanding.
// Zero-wait slave: cmd handshake at cycle 0, AW/W or AR at 1, B or R at 2, rsp_valid at 3.
// Held rsp_ready parks the block in RSP with cmd_ready low; optional counters via AXI4_LITE_CMD_MASTER_STATS_EN.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t C       = '{default: 0},
  parameter int unsigned    STATS_W = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [C.A-1:0]     cmd_addr,
  input  logic [C.N*8-1:0]   cmd_wdata,
  input  logic [C.N-1:0]     cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_write,
  output logic [C.N*8-1:0]   rsp_rdata,
  output logic [1:0]         rsp_resp,
  axi4_lite_if.master        axi4_m
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_wr_cnt,
  output logic [STATS_W-1:0] stat_rd_cnt,
  output logic [STATS_W-1:0] stat_err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t         state_q, state_d;
  axi4_lite_cmd_t cmd_q, cmd_d;
  axi4_lite_rsp_t rsp_q, rsp_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic           cmd_hs;
  logic           rsp_hs;
  logic           aw_fire;
  logic           w_fire;

  // The holding registers are sized for the widest bus; fold the spare
  // high bits so narrower configurations leave nothing dangling.
  logic           unused_hold_bits;
  assign unused_hold_bits = ^{cmd_q, rsp_q};

  assign cmd_ready = cmd_ready_q;
  assign cmd_hs    = cmd_valid & cmd_ready_q;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign aw_fire   = (state_q == WR_REQ) & ~aw_done_q & axi4_m.awready;
  assign w_fire    = (state_q == WR_REQ) & ~w_done_q & axi4_m.wready;

  assign rsp_write = rsp_q.write;
  assign rsp_rdata = rsp_q.rdata[C.N*8-1:0];
  assign rsp_resp  = rsp_q.resp;

  // Next-state, command/response capture and AXI channel drive.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    axi4_m.awvalid = 1'b0;
    axi4_m.awaddr  = cmd_q.addr[C.A-1:0];
    axi4_m.awprot  = 3'b000;
    axi4_m.wvalid  = 1'b0;
    axi4_m.wdata   = cmd_q.wdata[C.N*8-1:0];
    axi4_m.wstrb   = cmd_q.wstrb[C.N-1:0];
    axi4_m.bready  = 1'b0;
    axi4_m.arvalid = 1'b0;
    axi4_m.araddr  = cmd_q.addr[C.A-1:0];
    axi4_m.arprot  = 3'b000;
    axi4_m.rready  = 1'b0;
    rsp_valid      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          cmd_d                  = '0;
          cmd_d.write            = cmd_write;
          cmd_d.addr[C.A-1:0]    = cmd_addr;
          cmd_d.wdata[C.N*8-1:0] = cmd_wdata;
          cmd_d.wstrb[C.N-1:0]   = cmd_wstrb;
          aw_done_d              = 1'b0;
          w_done_d               = 1'b0;
          state_d                = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // Each channel is retired independently; leave once both are done.
        axi4_m.awvalid = ~aw_done_q;
        axi4_m.wvalid  = ~w_done_q;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        axi4_m.bready = 1'b1;
        if (axi4_m.bvalid) begin
          rsp_d.write = cmd_q.write;
          rsp_d.rdata = '0;
          rsp_d.resp  = axi4_lite_resp_t'(axi4_m.bresp);
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        axi4_m.arvalid = 1'b1;
        if (axi4_m.arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        axi4_m.rready = 1'b1;
        if (axi4_m.rvalid) begin
          rsp_d.write                = cmd_q.write;
          rsp_d.rdata                = '0;
          rsp_d.rdata[C.N*8-1:0]     = axi4_m.rdata;
          rsp_d.resp                 = axi4_lite_resp_t'(axi4_m.rresp);
          state_d                    = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered decode so cmd_ready never depends combinationally on cmd_valid.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and holding registers; reset discards any in-flight transaction.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
  axi4_lite_cmd_stats #(
    .STATS_W (STATS_W)
  ) u_stats (
    .aclk         (aclk),
    .areset       (areset),
    .rsp_hs       (rsp_hs),
    .rsp_write    (rsp_write),
    .rsp_err      (resp_is_err(rsp_resp)),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt)
  );
`endif

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Scoreboard bench for axi4_lite_cmd_master with a configurable-delay AXI4-Lite slave model.
// Inputs are driven on the falling edge; outputs are sampled shortly after it.
// Define AXI4_LITE_CMD_MASTER_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  localparam axi4_lite_cfg_t CFG = '{A: 32, N: 4};
  localparam int unsigned    SW  = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
  logic [SW-1:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  axi4_lite_if #(.C(CFG)) axi ();

  axi4_lite_cmd_master #(.C(CFG), .STATS_W(SW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi4_m    (axi)
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
    ,
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_hs_cyc = 0;

  // Slave configuration and expected request payload.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [31:0] rdata_cfg = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int          b_beats = 0, r_beats = 0;
  int          last_aw_hi = 0, last_w_hi = 0, last_ar_hi = 0;

  // Slave model state.
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_done = 0, w_done = 0, ar_done = 0, b_fire = 0, r_fire = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // AXI4-Lite slave: readies/valids decided mid-cycle for the coming edge.
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge aclk); #1;
      if (areset) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      // B channel: only after both AW and W handshakes have happened.
      if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
      else if (aw_done && w_done && !axi.bvalid) begin
        if (b_cnt >= b_dly) begin axi.bvalid = 1; axi.bresp = bresp_cfg; end
        else b_cnt++;
      end
      if (axi.bvalid && axi.bready) begin
        b_fire = 1; b_beats++; aw_done = 0; w_done = 0; b_cnt = 0;
      end
      // R channel: only after the AR handshake.
      if (r_fire) begin axi.rvalid = 0; r_fire = 0; end
      else if (ar_done && !axi.rvalid) begin
        if (r_cnt >= r_dly) begin axi.rvalid = 1; axi.rdata = rdata_cfg; axi.rresp = rresp_cfg; end
        else r_cnt++;
      end
      if (axi.rvalid && axi.rready) begin
        r_fire = 1; r_beats++; ar_done = 0; r_cnt = 0;
      end
      // AW channel.
      axi.awready = 0;
      if (axi.awvalid) begin
        chk("awaddr", axi.awaddr, exp_addr);
        chk("awprot", axi.awprot, 0);
        if (aw_cnt >= aw_dly) begin axi.awready = 1; aw_done = 1; last_aw_hi = aw_cnt + 1; aw_cnt = 0; end
        else aw_cnt++;
      end else aw_cnt = 0;
      // W channel.
      axi.wready = 0;
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, exp_wdata);
        chk("wstrb", axi.wstrb, exp_wstrb);
        if (w_cnt >= w_dly) begin axi.wready = 1; w_done = 1; last_w_hi = w_cnt + 1; w_cnt = 0; end
        else w_cnt++;
      end else w_cnt = 0;
      // AR channel.
      axi.arready = 0;
      if (axi.arvalid) begin
        chk("araddr", axi.araddr, exp_addr);
        chk("arprot", axi.arprot, 0);
        if (ar_cnt >= ar_dly) begin axi.arready = 1; ar_done = 1; last_ar_hi = ar_cnt + 1; ar_cnt = 0; end
        else ar_cnt++;
      end else ar_cnt = 0;
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    bit          in_rsp = 0;
    bit          stable = 1;
    int          first_cyc = 0;
    logic [34:0] snap = '0;
    exp_t        e;
    forever begin
      @(negedge aclk); #2;
      if (areset) begin in_rsp = 0; continue; end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1; stable = 1; first_cyc = cyc;
          snap = {rsp_write, rsp_rdata, rsp_resp};
        end else if ({rsp_write, rsp_rdata, rsp_resp} !== snap) stable = 0;
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: actual=1 response required=0 responses");
          end else begin
            e = sb.pop_front();
            chk("rsp_write", rsp_write, e.wr);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_stable", stable, 1);
            if (e.lat >= 0) chk("rsp_latency", first_cyc - last_hs_cyc, e.lat);
          end
          in_rsp = 0;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] exp_rd, input logic [1:0] exp_rsp,
                       input int lat, input bit push);
    int   guard = 0;
    exp_t e;
    @(negedge aclk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    exp_addr = addr; exp_wdata = wd; exp_wstrb = st;
    if (push) begin
      e.wr = wr; e.rdata = exp_rd; e.resp = exp_rsp; e.lat = lat;
      sb.push_back(e);
    end
    while (!cmd_ready && guard < 200) begin @(negedge aclk); guard++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept_timeout: actual cmd_ready=0 required=1");
    end
    last_hs_cyc = cyc;
    @(negedge aclk);
    // Scramble the inputs so any use of unlatched command fields shows up.
    cmd_valid = 0; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_wstrb = ~st; cmd_write = ~wr;
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while (sb.size() != 0 && g < 300) begin @(negedge aclk); g++; end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual=%0d pending responses required=0", nm, sb.size());
      sb.delete();
    end
    @(negedge aclk);
  endtask

  task automatic slave_cfg(input int awd, input int wd, input int bd, input int ard, input int rd);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
  endtask

  initial begin
    int b0;
    int blk;
    int g;
    exp_t e;
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    repeat (3) @(negedge aclk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, 0);
    chk("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    @(negedge aclk); areset = 0;
    @(negedge aclk); #2;
    chk("idle_cmd_ready", cmd_ready, 1);

    // SLVERR write response is passed through.
    slave_cfg(0, 0, 0, 0, 0); bresp_cfg = 2'd2;
    issue(1, 32'h0000_0040, 32'h1111_2222, 4'hF, 32'h0, 2'd2, 3, 1);
    wait_drain("slverr_wr");
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
    chk("stat_err_after_slverr", stat_err_cnt, 1);
    chk("stat_wr_after_slverr", stat_wr_cnt, 1);
`endif

    // Zero-wait write: rsp_valid three cycles after the command handshake.
    bresp_cfg = 2'd0; b0 = b_beats;
    issue(1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'd0, 3, 1);
    wait_drain("zero_wait_wr");
    chk("wr_b_beats", b_beats - b0, 1);

    // Read with 5 wait cycles on both AR and R.
    slave_cfg(0, 0, 0, 5, 5); rdata_cfg = 32'h1234_5678; rresp_cfg = 2'd0;
    issue(0, 32'h0000_0004, 32'h0, 4'h0, 32'h1234_5678, 2'd0, -1, 1);
    wait_drain("slow_rd");
    chk("arvalid_hold_cycles", last_ar_hi, 6);

    // awready delayed 3 cycles, wready immediate.
    slave_cfg(3, 0, 0, 0, 0); b0 = b_beats;
    issue(1, 32'h0000_000C, 32'hCAFE_F00D, 4'h5, 32'h0, 2'd0, -1, 1);
    wait_drain("aw_delay_wr");
    chk("awvalid_hold_cycles", last_aw_hi, 4);
    chk("wvalid_hold_cycles", last_w_hi, 1);
    chk("aw_delay_b_beats", b_beats - b0, 1);

    // DECERR read and EXOKAY write pass through unchanged.
    slave_cfg(0, 0, 1, 0, 2); rdata_cfg = 32'h0BAD_0BAD; rresp_cfg = 2'd3; bresp_cfg = 2'd1;
    issue(0, 32'h0000_0014, 32'h0, 4'h0, 32'h0BAD_0BAD, 2'd3, -1, 1);
    wait_drain("decerr_rd");
    issue(1, 32'h0000_0018, 32'h5A5A_A5A5, 4'h9, 32'h0, 2'd1, -1, 1);
    wait_drain("exokay_wr");
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
    chk("stat_wr_total", stat_wr_cnt, 4);
    chk("stat_rd_total", stat_rd_cnt, 2);
    chk("stat_err_total", stat_err_cnt, 2);
`endif

    // Response backpressure with a second command waiting.
    slave_cfg(0, 0, 0, 0, 0); bresp_cfg = 2'd0; rresp_cfg = 2'd0; rdata_cfg = 32'hA5A5_0001;
    rsp_ready = 0;
    issue(0, 32'h0000_0010, 32'h0, 4'h0, 32'hA5A5_0001, 2'd0, 3, 1);
    g = 0;
    while (!rsp_valid && g < 50) begin @(negedge aclk); g++; end
    chk("bp_rsp_valid_seen", rsp_valid, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h3;
    exp_addr = 32'h0000_0020; exp_wdata = 32'h0BAD_F00D; exp_wstrb = 4'h3;
    e.wr = 1; e.rdata = 32'h0; e.resp = 2'd0; e.lat = 3;
    sb.push_back(e);
    blk = 0;
    repeat (10) begin @(negedge aclk); if (cmd_ready) blk++; end
    chk("bp_cmd_ready_blocked", blk, 0);
    rsp_ready = 1;
    @(negedge aclk);
    chk("bp_cmd_ready_after", cmd_ready, 1);
    last_hs_cyc = cyc;
    @(negedge aclk);
    cmd_valid = 0; cmd_addr = '1;
    wait_drain("bp_second_cmd");

    // Reset in the middle of a write request phase.
    slave_cfg(3, 3, 0, 0, 0);
    issue(1, 32'h0000_0030, 32'h7777_8888, 4'hF, 32'h0, 2'd0, -1, 0);
    chk("mid_rst_awvalid_pre", axi.awvalid, 1);
    areset = 1;
    @(negedge aclk);
    chk("mid_rst_valids", {axi.awvalid, axi.wvalid}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge aclk); areset = 0;
    @(negedge aclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    slave_cfg(0, 0, 0, 0, 0); rdata_cfg = 32'h0000_BEEF;
    issue(0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_BEEF, 2'd0, 3, 1);
    wait_drain("post_rst_rd");
`ifdef AXI4_LITE_CMD_MASTER_STATS_EN
    chk("stat_rd_post_rst", stat_rd_cnt, 1);
    chk("stat_wr_post_rst", stat_wr_cnt, 0);
    chk("stat_err_post_rst", stat_err_cnt, 0);
`endif

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

endmodule
